pot_error_encoder: RTL

Power-of-two quantizer for the adaptive filter's sign-magnitude LMS update path. Accepts a 10-bit two's-complement error sample and encodes it into the control word consumed by the barrel-shifter weight-update multiplier: enable `x`, right-shift amount `sh[2:0]`, and sign `neg`. It sits between the error subtractor and the per-tap shifter array, and produces the encoding so that `(w AND x) >> sh` approximates `w * e / 256`. A small FSM performs a bit-serial leading-one search behind a valid/ready handshake.

---
 rtl/pot_error_encoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pot_error_encoder.sv
// pot_error_encoder: power-of-two quantizer for the sign-magnitude LMS update.
// Turns a 10-bit two's-complement error sample into {x, sh, neg} so that
// (w AND x) >> sh approximates w * e / 256.
// Optional macro POT_ENC_FAST_EN: one-cycle priority encoder instead of the
// bit-serial leading-one search (encoded outputs are identical).
module pot_error_encoder (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_e,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic       o_x,
    output logic [2:0] o_sh,
    output logic       o_neg,
    output logic       o_out_valid,
    input  logic       i_out_ready
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [8:0] r_mag;
    logic       r_neg_s;
    logic       r_x;
    logic [2:0] r_sh;
    logic       r_neg;
    logic       r_out_valid;

    logic [9:0] w_abs;
    logic [8:0] w_mag;
    logic       w_found;
    logic       w_done;
    logic [2:0] w_sh_next;

    // Magnitude of the incoming sample; -512 has no 9-bit magnitude, clamp to 511
    always_comb begin
        w_abs = i_e[9] ? (~i_e + 10'd1) : i_e;
        w_mag = (i_e == 10'h200) ? 9'd511 : w_abs[8:0];
    end

`ifdef POT_ENC_FAST_EN
    logic       w_fp_hit;
    logic [2:0] w_fp_sh;

    // Priority encoder over mag[8:1]; ascending loop so the highest set bit wins
    always_comb begin
        w_fp_hit = 1'b0;
        w_fp_sh  = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            if (r_mag[i]) begin
                w_fp_hit = 1'b1;
                w_fp_sh  = 3'(8 - i);
            end
        end
        w_found   = w_fp_hit;
        w_done    = 1'b1;
        w_sh_next = w_fp_sh;
    end
`else
    logic [3:0] w_diff;

    // Serial search: examine mag[cnt]; bit 0 is never a candidate so stop at cnt == 1
    always_comb begin
        w_diff    = 4'd8 - r_cnt;
        w_found   = r_mag[r_cnt];
        w_done    = w_found || (r_cnt == 4'd1);
        w_sh_next = w_diff[2:0];
    end
`endif

    // Control FSM with registered outputs; out_valid rises one cycle after HOLD entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd8;
            r_mag       <= 9'd0;
            r_neg_s     <= 1'b0;
            r_x         <= 1'b0;
            r_sh        <= 3'd0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_neg_s <= i_e[9];
                        r_mag   <= w_mag;
                        r_cnt   <= 4'd8;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_done) begin
                        r_x     <= w_found;
                        r_sh    <= w_found ? w_sh_next : 3'd0;
                        r_neg   <= r_neg_s;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE) && !i_rst;
    assign o_x         = r_x;
    assign o_sh        = r_sh;
    assign o_neg       = r_neg;
    assign o_out_valid = r_out_valid;

endmodule
